// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO with a valid/ready write port.
// Supports configurable data width, parity and stop bits, and sends queued frames back-to-back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 27,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          tx_bsy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = 4;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~^d : ^d;
  endfunction

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic                 push;
  logic                 pop;
  logic                 empty;

  state_t               state;
  state_t               state_nxt;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic                 bit_end;
  logic                 line_nxt;

  logic [DATA_BITS-1:0] shift_p0;
  logic                 par_p0;
  logic                 tx_p1;
  logic                 bsy_p1;

  assign in_ready   = (level != FULL_LVL);
  assign push       = in_valid && in_ready;
  assign empty      = (level == '0);
  assign fifo_level = level;
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign tx         = tx_p1;
  assign tx_bsy     = bsy_p1;

  // FIFO control: pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    line_nxt  = 1'b1;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        line_nxt = 1'b0;
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        line_nxt = shift_p0[0];
        if (bit_end && bit_cnt == DATA_LAST) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        line_nxt = par_p0;
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_end && bit_cnt == STOP_LAST) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: frame sequencing, FIFO storage and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;
      if (state_nxt != state)
        bit_cnt <= '0;
      else if (bit_end && (state == S_DATA || state == S_STOP))
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
    if (pop) begin
      shift_p0 <= mem[rd_ptr];
      par_p0   <= frame_parity(mem[rd_ptr]);
    end else if (state == S_DATA && bit_end) begin
      shift_p0 <= shift_p0 >> 1;
    end
  end

  // Stage p1: registered line driver, one clock behind the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_p1  <= 1'b1;
      bsy_p1 <= 1'b0;
    end else begin
      tx_p1  <= line_nxt;
      bsy_p1 <= (state != S_IDLE);
    end
  end

endmodule
